// File: rtl/rf_port_sched_pkg.sv
// Shared constants and state type for the register-file port scheduler.
package rf_port_sched_pkg;

  localparam int RF_DEPTH = 32;  // entries in the RAM
  localparam int RF_AW    = 5;   // RAM address width
  localparam int RF_NRP   = 3;   // physical read ports on the RAM

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin picker: grants up to RF_NRP valid requesters,
// scanning from ptr and wrapping modulo NRD. Reports which requester each
// physical port serves and where the next scan should start.
module rr_multi_grant
  import rf_port_sched_pkg::*;
#(
  parameter int NRD = 4,
  localparam int PW = $clog2(NRD)
) (
  input  logic [NRD-1:0]    valid,
  input  logic [PW-1:0]     ptr,
  output logic [NRD-1:0]    grant,
  output logic [RF_NRP-1:0] port_used,
  output logic [PW-1:0]     port_idx [RF_NRP],
  output logic [PW-1:0]     next_ptr
);

  logic [PW-1:0] idx;
  logic [PW-1:0] last;
  logic [1:0]    cnt;

  // Walk the requesters in rotated order and hand out ports in scan order.
  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    grant     = '0;
    port_used = '0;
    for (int k = 0; k < RF_NRP; k++) port_idx[k] = '0;
    next_ptr  = ptr;
    idx       = '0;
    last      = '0;
    cnt       = '0;
    for (int o = 0; o < NRD; o++) begin
      idx = PW'((int'(ptr) + o) % NRD);
      if (valid[idx] && (cnt != 2'(RF_NRP))) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < RF_NRP; k++) begin
          if (cnt == 2'(k)) begin
            port_used[k] = 1'b1;
            port_idx[k]  = idx;
          end
        end
        last = idx;
        cnt  = cnt + 2'd1;
      end
    end
    if (cnt != 2'd0) next_ptr = (last == PW'(NRD - 1)) ? '0 : last + PW'(1);
  end

endmodule

// File: rtl/rf_port_sched.sv
// Port scheduler for a 32x(3R/1W) RAM: clears the RAM after reset, then
// shares the read ports round-robin and the write port by fixed priority.
// Read results are registered; a same-cycle write to the read address is
// forwarded so reads see write-first data.
module rf_port_sched
  import rf_port_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NRD   = 4,
  parameter int NWR   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD-1:0]         rd_req_valid,
  input  logic [NRD*RF_AW-1:0]   rd_req_addr,
  output logic [NRD-1:0]         rd_req_ready,
  output logic [NRD-1:0]         rd_resp_valid,
  output logic [NRD*WIDTH-1:0]   rd_resp_data,
  input  logic [NWR-1:0]         wr_req_valid,
  input  logic [NWR*RF_AW-1:0]   wr_req_addr,
  input  logic [NWR*WIDTH-1:0]   wr_req_data,
  output logic [NWR-1:0]         wr_req_ready,
  output logic                   init_done,
  output logic [RF_AW-1:0]       mem_addr0,
  output logic [RF_AW-1:0]       mem_addr1,
  output logic [RF_AW-1:0]       mem_addr2,
  input  logic [WIDTH-1:0]       mem_dout0,
  input  logic [WIDTH-1:0]       mem_dout1,
  input  logic [WIDTH-1:0]       mem_dout2,
  output logic [RF_AW-1:0]       mem_addrw,
  output logic [WIDTH-1:0]       mem_din,
  output logic                   mem_wea
);

  localparam int PW = $clog2(NRD);

  sched_state_e      state;
  logic [RF_AW-1:0]  init_cnt;
  logic [PW-1:0]     rr_ptr;
  logic              running;

  logic [NRD-1:0]    rd_grant;
  logic [RF_NRP-1:0] port_used;
  logic [PW-1:0]     port_idx [RF_NRP];
  logic [PW-1:0]     next_ptr;

  logic [RF_AW-1:0]  rd_addr   [NRD];
  logic [RF_AW-1:0]  port_addr [RF_NRP];
  logic [WIDTH-1:0]  port_dout [RF_NRP];
  logic [WIDTH-1:0]  rd_fresh  [NRD];

  assign running   = (state == S_RUN);
  assign init_done = running;

  // Read requests are ignored entirely while the clear sequence runs.
  rr_multi_grant #(.NRD(NRD)) u_rr (
    .valid    (rd_req_valid & {NRD{running}}),
    .ptr      (rr_ptr),
    .grant    (rd_grant),
    .port_used(port_used),
    .port_idx (port_idx),
    .next_ptr (next_ptr)
  );

  assign rd_req_ready = rd_grant;

  assign mem_addr0    = port_addr[0];
  assign mem_addr1    = port_addr[1];
  assign mem_addr2    = port_addr[2];
  assign port_dout[0] = mem_dout0;
  assign port_dout[1] = mem_dout1;
  assign port_dout[2] = mem_dout2;

  // Unpack requester addresses and steer the granted ones onto the RAM ports.
  always_comb begin
    for (int i = 0; i < NRD; i++) rd_addr[i] = rd_req_addr[i*RF_AW +: RF_AW];
    for (int k = 0; k < RF_NRP; k++) begin
      port_addr[k] = port_used[k] ? rd_addr[port_idx[k]] : '0;
    end
  end

  // Write port: clear pattern during INIT, lowest-index valid requester in RUN.
  always_comb begin
    wr_req_ready = '0;
    mem_wea      = 1'b0;
    mem_addrw    = '0;
    mem_din      = '0;
    if (!running) begin
      mem_wea   = 1'b1;
      mem_addrw = init_cnt;
    end else begin
      // Descending scan so the lowest valid index is the last one written.
      for (int j = NWR - 1; j >= 0; j--) begin
        if (wr_req_valid[j]) begin
          wr_req_ready    = '0;
          wr_req_ready[j] = 1'b1;
          mem_wea         = 1'b1;
          mem_addrw       = wr_req_addr[j*RF_AW +: RF_AW];
          mem_din         = wr_req_data[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Per-requester read value: its port's RAM data, or the write data when
  // the write in this same cycle targets the same entry.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_fresh[i] = '0;
      for (int k = 0; k < RF_NRP; k++) begin
        if (port_used[k] && (port_idx[k] == PW'(i))) rd_fresh[i] = port_dout[k];
      end
      if (mem_wea && (mem_addrw == rd_addr[i])) rd_fresh[i] = mem_din;
    end
  end

  // Sequencer state, round-robin pointer and registered read responses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      rr_ptr        <= '0;
      rd_resp_valid <= '0;
      rd_resp_data  <= '0;
    end else begin
      rd_resp_valid <= rd_grant;
      for (int i = 0; i < NRD; i++) begin
        if (rd_grant[i]) rd_resp_data[i*WIDTH +: WIDTH] <= rd_fresh[i];
      end
      if (state == S_INIT) begin
        init_cnt <= init_cnt + RF_AW'(1);
        if (init_cnt == RF_AW'(RF_DEPTH - 1)) state <= S_RUN;
      end else begin
        rr_ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_rf_port_sched.sv
// Self-checking bench for rf_port_sched: a behavioural RAM, a spec-level
// reference model compared every cycle, and directed literal checks.
module tb_rf_port_sched;

  localparam int WIDTH = 32;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD-1:0]       rd_req_valid;
  logic [NRD*AW-1:0]    rd_req_addr;
  logic [NRD-1:0]       rd_req_ready;
  logic [NRD-1:0]       rd_resp_valid;
  logic [NRD*WIDTH-1:0] rd_resp_data;
  logic [NWR-1:0]       wr_req_valid;
  logic [NWR*AW-1:0]    wr_req_addr;
  logic [NWR*WIDTH-1:0] wr_req_data;
  logic [NWR-1:0]       wr_req_ready;
  logic                 init_done;
  logic [AW-1:0]        mem_addr0, mem_addr1, mem_addr2, mem_addrw;
  logic [WIDTH-1:0]     mem_dout0, mem_dout1, mem_dout2, mem_din;
  logic                 mem_wea;

  always #5 clk = ~clk;

  rf_port_sched #(.WIDTH(WIDTH), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_ready(wr_req_ready), .init_done(init_done),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_dout0(mem_dout0), .mem_dout1(mem_dout1), .mem_dout2(mem_dout2),
    .mem_addrw(mem_addrw), .mem_din(mem_din), .mem_wea(mem_wea)
  );

  // Behavioural 3R/1W RAM: async read, sync write.
  logic [WIDTH-1:0] ram [32];
  always @(posedge clk) if (mem_wea) ram[mem_addrw] <= mem_din;
  assign mem_dout0 = ram[mem_addr0];
  assign mem_dout1 = ram[mem_addr1];
  assign mem_dout2 = ram[mem_addr2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_live = 1'b0;
  bit               m_init;
  int               m_cnt, m_ptr;
  logic [WIDTH-1:0] m_mem [32];
  logic [NRD-1:0]   m_rv;
  logic [NRD*WIDTH-1:0] m_rd;

  logic [NRD-1:0]   e_rready;
  logic [NWR-1:0]   e_wready;
  logic             e_wea;
  logic [AW-1:0]    e_waddr;
  logic [WIDTH-1:0] e_din;
  logic [AW-1:0]    e_addr [3];
  logic [AW-1:0]    m_a;
  int               q[$];
  int               win;

  // Compute what the outputs must be from the model state and current inputs,
  // compare, then advance the model to its post-edge state.
  always @(negedge clk) begin
    e_rready = '0; e_wready = '0; e_wea = 1'b0; e_waddr = '0; e_din = '0;
    for (int k = 0; k < 3; k++) e_addr[k] = '0;
    q.delete();
    if (m_init) begin
      e_wea   = 1'b1;
      e_waddr = AW'(m_cnt);
    end else begin
      win = -1;
      for (int j = 0; j < NWR; j++) if (win < 0 && wr_req_valid[j]) win = j;
      if (win >= 0) begin
        e_wready[win] = 1'b1;
        e_wea   = 1'b1;
        e_waddr = wr_req_addr[win*AW +: AW];
        e_din   = wr_req_data[win*WIDTH +: WIDTH];
      end
      for (int o = 0; o < NRD; o++)
        if (rd_req_valid[(m_ptr + o) % NRD]) q.push_back((m_ptr + o) % NRD);
      while (q.size() > 3) void'(q.pop_back());
      foreach (q[k]) begin
        e_rready[q[k]] = 1'b1;
        e_addr[k] = rd_req_addr[q[k]*AW +: AW];
      end
    end

    if (m_live) begin
      check("init_done", init_done, !m_init);
      check("rd_req_ready", rd_req_ready, e_rready);
      check("wr_req_ready", wr_req_ready, e_wready);
      check("mem_wea", mem_wea, e_wea);
      if (e_wea) begin
        check("mem_addrw", mem_addrw, e_waddr);
        check("mem_din", mem_din, e_din);
      end
      check("mem_addr0", mem_addr0, e_addr[0]);
      check("mem_addr1", mem_addr1, e_addr[1]);
      check("mem_addr2", mem_addr2, e_addr[2]);
      check("rd_resp_valid", rd_resp_valid, m_rv);
      check("rd_resp_data", rd_resp_data, m_rd);
    end

    if (rst) begin
      m_live = 1'b1; m_init = 1'b1; m_cnt = 0; m_ptr = 0; m_rv = '0; m_rd = '0;
    end else if (m_live) begin
      m_rv = e_rready;
      foreach (q[k]) begin
        m_a = rd_req_addr[q[k]*AW +: AW];
        m_rd[q[k]*WIDTH +: WIDTH] = (e_wea && e_waddr == m_a) ? e_din : m_mem[m_a];
      end
      if (e_wea) m_mem[e_waddr] = e_din;
      if (m_init) begin
        if (m_cnt == 31) m_init = 1'b0;
        m_cnt++;
      end else if (q.size() > 0) begin
        m_ptr = (q[q.size()-1] + 1) % NRD;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req_valid = '0;
    wr_req_valid = '0;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_req_valid[i] = 1'b1;
    rd_req_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_req_valid[j] = 1'b1;
    wr_req_addr[j*AW +: AW] = a;
    wr_req_data[j*WIDTH +: WIDTH] = d;
  endtask

  logic [NRD-1:0] rr_exp [4];

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'hA5A5_0000 | i;
    rr_exp[0] = 4'b0111; rr_exp[1] = 4'b1011; rr_exp[2] = 4'b1101; rr_exp[3] = 4'b1110;

    // Reset with every requester hammering.
    rst = 1'b1;
    rd_req_valid = '1;
    rd_req_addr  = {5'd9, 5'd8, 5'd7, 5'd6};
    wr_req_valid = '1;
    wr_req_addr  = {5'd2, 5'd1};
    wr_req_data  = {32'h2222_2222, 32'h1111_1111};
    tick(); tick();
    rst = 1'b0;

    // Clear sequence: 32 cycles, no grants, addrw walks 0..31 with zero data.
    for (int n = 0; n < 32; n++) begin
      #1;
      check("init_busy", init_done, 1'b0);
      check("init_addrw", mem_addrw, n);
      check("init_din", mem_din, 0);
      check("init_rd_ready", rd_req_ready, 4'b0000);
      check("init_wr_ready", wr_req_ready, 2'b00);
      tick();
    end
    idle();
    #1;
    check("init_done_at_32", init_done, 1'b1);

    // Every entry reads back as zero.
    for (int a = 0; a < 32; a++) begin
      idle();
      set_rd(0, AW'(a));
      tick();
      check("clear_rd_valid", rd_resp_valid, 4'b0001);
      check("clear_rd_data", rd_resp_data[31:0], 32'h0);
    end
    // Requester 3 alone brings the pointer back to 0.
    idle(); set_rd(3, 5'd0);
    tick(); idle();

    // Round-robin rotation with all four valid.
    for (int i = 0; i < 4; i++) set_rd(i, AW'(i + 10));
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rr_grant", rd_req_ready, rr_exp[c]);
      tick();
    end
    idle();

    // Write-first bypass on a same-cycle read.
    set_wr(0, 5'd5, 32'hDEAD_BEEF);
    set_rd(1, 5'd5);
    #1;
    check("byp_wr_ready", wr_req_ready, 2'b01);
    check("byp_rd_ready", rd_req_ready, 4'b0010);
    tick(); idle();
    check("byp_valid", rd_resp_valid, 4'b0010);
    check("byp_data", rd_resp_data[63:32], 32'hDEAD_BEEF);

    // Fixed-priority writes; loser stalls one cycle.
    set_wr(0, 5'd3, 32'h11);
    set_wr(1, 5'd4, 32'h22);
    #1;
    check("prio_first", wr_req_ready, 2'b01);
    tick();
    wr_req_valid[0] = 1'b0;
    #1;
    check("prio_second", wr_req_ready, 2'b10);
    check("prio_second_addr", mem_addrw, 5'd4);
    tick(); idle();
    set_rd(0, 5'd3); set_rd(1, 5'd4);
    tick(); idle();
    check("prio_rd_valid", rd_resp_valid, 4'b0011);
    check("prio_rd0", rd_resp_data[31:0], 32'h11);
    check("prio_rd1", rd_resp_data[63:32], 32'h22);

    // Single requester: port 0 only, others parked at 0.
    set_rd(2, 5'd7);
    #1;
    check("single_addr0", mem_addr0, 5'd7);
    check("single_addr1", mem_addr1, 5'd0);
    check("single_addr2", mem_addr2, 5'd0);
    tick(); idle();
    check("single_valid", rd_resp_valid, 4'b0100);
    check("single_data", rd_resp_data[95:64], 32'h0);
    // Pointer now at 3.
    for (int i = 0; i < 4; i++) set_rd(i, AW'(i));
    #1;
    check("ptr_after_single", rd_req_ready, 4'b1011);
    tick(); idle();

    // Reset right after a grant drops the response and restarts the clear.
    set_rd(0, 5'd5);
    tick(); idle();
    rst = 1'b1;
    #1;
    check("pre_rst_valid", rd_resp_valid, 4'b0001);
    check("pre_rst_data", rd_resp_data[31:0], 32'hDEAD_BEEF);
    tick();
    rst = 1'b0;
    #1;
    check("rst_valid", rd_resp_valid, 4'b0000);
    check("rst_init_done", init_done, 1'b0);
    check("rst_addrw", mem_addrw, 5'd0);
    tick();
    #1;
    check("rst_addrw_next", mem_addrw, 5'd1);
    for (int n = 0; n < 34; n++) tick();
    #1;
    check("reinit_done", init_done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_port_sched.md
Name: rf_port_sched

Overview:
- Port scheduler and initialiser for a 32-entry, 3-read/1-write RAM (async read, sync write on clk when wea is high).
- Shares the 3 read ports among NRD requesters using round-robin, and the single write port among NWR requesters using fixed priority.
- Registers read results and forwards same-cycle writes, giving write-first semantics.
- After reset, clears all 32 entries to zero before accepting any traffic.

Parameters:
- WIDTH, 32, data width per entry.
- NRD, 4, number of read requesters (3..8).
- NWR, 2, number of write requesters (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rd_req_valid  in  NRD  read request valid, one bit per requester.
- rd_req_addr  in  NRD*5  read addresses, requester i at bits [5i+4:5i].
- rd_req_ready  out  NRD  read grant this cycle (combinational from valid).
- rd_resp_valid  out  NRD  read data valid, one cycle after grant.
- rd_resp_data  out  NRD*WIDTH  registered read data.
- wr_req_valid  in  NWR  write request valid.
- wr_req_addr  in  NWR*5  write addresses.
- wr_req_data  in  NWR*WIDTH  write data.
- wr_req_ready  out  NWR  write grant.
- init_done  out  1  high once the clear sequence is complete.
- mem_addr0, mem_addr1, mem_addr2  out  5 each  RAM read addresses.
- mem_dout0, mem_dout1, mem_dout2  in  WIDTH each  RAM read data (combinational).
- mem_addrw  out  5  RAM write address.
- mem_din  out  WIDTH  RAM write data.
- mem_wea  out  1  RAM write enable.

Behaviour:
- States: INIT, RUN.
- Reset forces INIT and clears the state: init counter = 0, rr_ptr = 0, rd_resp_valid = 0, rd_resp_data = 0, init_done = 0.
- INIT:
  - mem_wea = 1, mem_addrw = counter, mem_din = 0.
  - All ready outputs are 0 and no read grants are issued.
  - The counter increments every cycle. On the cycle that writes entry 31, the next state is RUN.
  - INIT therefore lasts exactly 32 cycles. init_done = 1 from the first RUN cycle onward.
- RUN, read arbitration:
  - Scan requesters starting at rr_ptr, wrapping modulo NRD. Grant the first up to 3 valid requesters in scan order.
  - The k-th grant (k = 0..2) uses mem_addr{k}. Unused mem_addr{k} = 0.
  - If at least one grant is made, rr_ptr <= (index of last granted requester + 1) mod NRD. Otherwise rr_ptr holds.
  - If 3 or fewer requesters are valid, all of them are granted.
- RUN, read response:
  - The cycle after a grant: rd_resp_valid[i] = 1 and rd_resp_data[i] = the value sampled at the grant edge. Ungranted requesters get rd_resp_valid = 0 and their data holds.
  - Bypass: if mem_wea is high in the grant cycle and mem_addrw equals the read address, the response carries mem_din instead of mem_dout.
  - Address 0 is an ordinary entry and gets no special treatment.
- RUN, write arbitration:
  - The lowest-index valid requester wins and only it sees ready = 1.
  - mem_wea = 1 with the winner's address and data. If no requester is valid, mem_wea = 0.
  - Losers stall, holding valid high until granted.
- Reset asserted mid-operation: any pending responses are dropped (rd_resp_valid = 0 next cycle) and the clear sequence restarts from entry 0.
- Latency: read 1 cycle; write visible to a read granted the same cycle via bypass, and to any later read through the RAM.

Decomposition:
- Shared package: constants RF_DEPTH = 32, RF_AW = 5, RF_NRP = 3; enum sched_state_e {S_INIT, S_RUN}.
- One natural sub-module: rr_multi_grant, a combinational pick of up to 3 from NRD requesters starting at a pointer. It outputs the grant vector, per-port requester index, and next pointer.

Test Plan:
- Reset, then hold all valids high -> all readies 0 for 32 cycles; mem_addrw steps 0..31 with din = 0; init_done = 1 at cycle 32; every read of entries 0..31 afterwards returns 0.
- RUN, NRD = 4, all 4 valid for 4 consecutive cycles starting at rr_ptr = 0 -> grants {0,1,2}, then {3,0,1}, then {2,3,0}, then {1,2,3}; every requester is served within 2 cycles.
- wr0 writes addr 5 = 0xDEADBEEF while rd1 reads addr 5 in the same cycle -> next cycle rd_resp_valid[1] = 1 and rd_resp_data[1] = 0xDEADBEEF.
- wr0 and wr1 both valid (addr 3 = 0x11, addr 4 = 0x22) -> wr0 granted in cycle 1, wr1 in cycle 2; later reads return 0x11 and 0x22.
- Only rd2 valid, addr 7 -> mem_addr0 = 7, mem_addr1 = mem_addr2 = 0; rr_ptr becomes 3; only rd_resp_valid[2] is set.
- Read granted, then rst = 1 on the next cycle -> rd_resp_valid = 0 and init_done = 0; the clear sequence restarts at address 0.
